lru_ctrl: RTL and testbench

Read-modify-write controller for the 4-way true-LRU state of the set-associative cache. It sits directly upstream of `lrutbl`, the 64×8 block RAM with registered read and read-first behaviour, and owns every access to that RAM. The block initialises all entries after reset, accepts touch/allocate requests from the cache FSM and returns the way to use. It then writes back the updated ages.

---
 rtl/lru_ctrl.sv | 146 ++++++++++++++
 tb/tb_lru_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lru_ctrl.sv
// lru_ctrl: read-modify-write controller for the 4-way true-LRU age table.
// Initialises every entry, then serves touch/allocate requests with one read and one write-back each.
`default_nettype none

module lru_ctrl #(
  parameter int          SET_BITS   = 6,
  parameter logic [7:0]  INIT_ENTRY = 8'h1B
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SET_BITS-1:0] req_set,
  input  logic                req_op,
  input  logic [1:0]          req_way,
  output logic                rsp_valid,
  output logic [1:0]          rsp_way,
  output logic                init_done,
  output logic                tbl_ena,
  output logic                tbl_wea,
  output logic [SET_BITS-1:0] tbl_addr,
  output logic [7:0]          tbl_din,
  input  logic [7:0]          tbl_dout
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    UPD  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [SET_BITS-1:0] cnt;
  logic [SET_BITS-1:0] set_q;
  logic                op_q;
  logic [1:0]          way_q;
  logic [1:0]          last_way;
  logic [1:0]          victim;
  logic [1:0]          target;
  logic [1:0]          target_age;
  logic [7:0]          new_entry;
  logic                accept;

  assign accept = (state == IDLE) && req_valid;

  // Scan from the top so the lowest-index way with age 3 wins; corrupt entries fall back to way 0.
  always_comb begin
    victim = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (tbl_dout[2*i +: 2] == 2'd3) begin
        victim = 2'(i);
      end
    end
  end

  assign target     = op_q ? victim : way_q;
  assign target_age = tbl_dout[2*target +: 2];

  always_comb begin
    new_entry = tbl_dout;
    for (int j = 0; j < 4; j++) begin
      if (2'(j) == target) begin
        new_entry[2*j +: 2] = 2'd0;
      end else if (tbl_dout[2*j +: 2] < target_age) begin
        new_entry[2*j +: 2] = tbl_dout[2*j +: 2] + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      cnt      <= '0;
      set_q    <= '0;
      op_q     <= 1'b0;
      way_q    <= 2'd0;
      last_way <= 2'd0;
    end else begin
      state <= state_nx;
      if (state == INIT) begin
        cnt <= cnt + 1'b1;
      end
      if (accept) begin
        set_q <= req_set;
        op_q  <= req_op;
        way_q <= req_way;
      end
      if (state == UPD) begin
        last_way <= target;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_way   = 2'd0;
    init_done = 1'b0;
    tbl_ena   = 1'b0;
    tbl_wea   = 1'b0;
    tbl_addr  = '0;
    tbl_din   = 8'h00;
    // Reset masks every output combinationally so a mid-UPD reset issues no write or response.
    if (!rst) begin
      rsp_way = last_way;
      case (state)
        INIT: begin
          tbl_ena  = 1'b1;
          tbl_wea  = 1'b1;
          tbl_addr = cnt;
          tbl_din  = INIT_ENTRY;
          if (cnt == {SET_BITS{1'b1}}) begin
            state_nx = IDLE;
          end
        end
        IDLE: begin
          req_ready = 1'b1;
          init_done = 1'b1;
          if (req_valid) begin
            tbl_ena  = 1'b1;
            tbl_addr = req_set;
            state_nx = UPD;
          end
        end
        UPD: begin
          init_done = 1'b1;
          tbl_ena   = 1'b1;
          tbl_wea   = 1'b1;
          tbl_addr  = set_q;
          tbl_din   = new_entry;
          rsp_valid = 1'b1;
          rsp_way   = target;
          state_nx  = IDLE;
        end
        default: begin
          state_nx = INIT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lru_ctrl.sv
// tb_lru_ctrl: directed checks of lru_ctrl against a read-first 64x8 table model.
`default_nettype none

module tb_lru_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_set;
  logic       req_op;
  logic [1:0] req_way;
  logic       rsp_valid;
  logic [1:0] rsp_way;
  logic       init_done;
  logic       tbl_ena;
  logic       tbl_wea;
  logic [5:0] tbl_addr;
  logic [7:0] tbl_din;
  logic [7:0] tbl_dout;

  logic [7:0] mem [64];
  logic [7:0] ram_dout = 8'h00;
  logic       ovr_en;
  logic [7:0] ovr_val;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lru_ctrl #(.SET_BITS(6), .INIT_ENTRY(8'h1B)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_set   (req_set),
    .req_op    (req_op),
    .req_way   (req_way),
    .rsp_valid (rsp_valid),
    .rsp_way   (rsp_way),
    .init_done (init_done),
    .tbl_ena   (tbl_ena),
    .tbl_wea   (tbl_wea),
    .tbl_addr  (tbl_addr),
    .tbl_din   (tbl_din),
    .tbl_dout  (tbl_dout)
  );

  // Registered read, read-first; the override lets a test inject arbitrary entries.
  always @(posedge clk) begin
    if (tbl_ena) begin
      ram_dout <= mem[tbl_addr];
      if (tbl_wea) mem[tbl_addr] <= tbl_din;
    end
  end
  assign tbl_dout = ovr_en ? ovr_val : ram_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after rst drops: expects 64 init writes then IDLE.
  task automatic init_seq();
    for (int i = 0; i < 64; i++) begin
      chk("init_wr", {tbl_ena, tbl_wea, tbl_addr, tbl_din, req_ready, init_done},
          {1'b1, 1'b1, 6'(i), 8'h1B, 1'b0, 1'b0});
      tick();
    end
    chk("idle_ready", {req_ready, init_done, tbl_ena}, {1'b1, 1'b1, 1'b0});
  endtask

  task automatic do_req(input logic [5:0] s, input logic op, input logic [1:0] w,
                        input logic [1:0] exp_way, input logic [7:0] exp_din);
    req_valid = 1'b1;
    req_set   = s;
    req_op    = op;
    req_way   = w;
    #1;
    chk("accept", {req_ready, tbl_ena, tbl_wea, tbl_addr, rsp_valid},
        {1'b1, 1'b1, 1'b0, s, 1'b0});
    tick();
    req_valid = 1'b0;
    chk("upd", {rsp_valid, rsp_way, req_ready, tbl_ena, tbl_wea, tbl_addr},
        {1'b1, exp_way, 1'b0, 1'b1, 1'b1, s});
    chk("upd_din", tbl_din, exp_din);
    tick();
    chk("after", {rsp_valid, rsp_way, req_ready, tbl_wea}, {1'b0, exp_way, 1'b1, 1'b0});
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_set   = '0;
    req_op    = 1'b0;
    req_way   = 2'd0;
    ovr_en    = 1'b0;
    ovr_val   = 8'h00;
    repeat (3) tick();
    chk("rst_out", {req_ready, rsp_valid, rsp_way, init_done, tbl_ena, tbl_wea},
        {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0});

    rst = 1'b0;
    #1;
    init_seq();

    // Allocate chain on a fresh set walks the ways 0,1,2,3,0.
    do_req(6'd5, 1'b1, 2'd0, 2'd0, 8'h6C);
    do_req(6'd5, 1'b1, 2'd0, 2'd1, 8'hB1);
    do_req(6'd5, 1'b1, 2'd0, 2'd2, 8'hC6);
    do_req(6'd5, 1'b1, 2'd0, 2'd3, 8'h1B);
    do_req(6'd5, 1'b1, 2'd0, 2'd0, 8'h6C);

    do_req(6'd9, 1'b0, 2'd3, 2'd3, 8'h1B);
    do_req(6'd9, 1'b0, 2'd0, 2'd0, 8'h6C);
    do_req(6'd9, 1'b1, 2'd2, 2'd1, 8'hB1);

    ovr_en  = 1'b1;
    ovr_val = 8'hFF;
    do_req(6'd20, 1'b1, 2'd3, 2'd0, 8'hFC);
    ovr_val = 8'h00;
    do_req(6'd20, 1'b1, 2'd3, 2'd0, 8'h00);
    ovr_en  = 1'b0;

    // Held request: accepts on alternate cycles, response one cycle after each.
    req_valid = 1'b1;
    req_op    = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      req_set = 6'(k);
      #1;
      chk("b2b_acc", {req_ready, tbl_ena, tbl_wea, tbl_addr, rsp_valid},
          {1'b1, 1'b1, 1'b0, 6'(k), 1'b0});
      tick();
      chk("b2b_upd", {req_ready, tbl_wea, tbl_addr, rsp_valid, rsp_way, tbl_din},
          {1'b0, 1'b1, 6'(k), 1'b1, 2'd0, 8'h6C});
      tick();
    end
    req_valid = 1'b0;
    #1;
    chk("b2b_end", {req_ready, rsp_valid, tbl_ena}, {1'b1, 1'b0, 1'b0});

    // Reset during UPD: nothing leaks out, then a full re-init.
    req_valid = 1'b1;
    req_set   = 6'd30;
    req_op    = 1'b0;
    req_way   = 2'd0;
    tick();
    req_valid = 1'b0;
    chk("pre_rst_upd", rsp_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_upd", {rsp_valid, tbl_wea, tbl_ena, req_ready, init_done, rsp_way},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
    tick();
    rst = 1'b0;
    #1;
    init_seq();
    do_req(6'd30, 1'b0, 2'd3, 2'd3, 8'h1B);
    do_req(6'd5, 1'b1, 2'd0, 2'd0, 8'h6C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
